// File: rtl/ihs_pkg.sv
// Shared IHS core definitions: opcode constants, the NOP word and the fetch FSM encoding.
package ihs_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LDI = 3'b010;
    localparam logic [2:0] OP_HLT = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;

    // OUT r0 with no register write: harmless word to present out of reset
    localparam logic [15:0] NOP_WORD = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_hlt(input logic [15:0] word);
        return word[15:13] == OP_HLT;
    endfunction
endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a prefetched instruction word.
// Load wins over pop in the same cycle; flush wins over both.
module fetch_buffer
    import ihs_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] load_dat_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic        vld_o,
    output logic [15:0] dat_o
);
    logic        vld_q;
    logic [15:0] dat_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= NOP_WORD;
        end else begin
            if (flush_i || pop_i) begin
                vld_q <= 1'b0;
            end
            if (load_i && !flush_i) begin
                vld_q <= 1'b1;
                dat_q <= load_dat_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one read at a time, word held stable until the control unit acks it; HLT freezes fetch.
// Defining IHS_FETCH_PREFETCH_EN adds a one-word prefetch buffer (fetch_buffer) that removes the FETCH bubble.
module instr_fetch
    import ihs_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    output logic            mem_rd_en,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_rvalid,
    output logic [15:0]     instruction,
    output logic            instr_valid,
    input  logic            instr_ack,
    output logic [PC_W-1:0] pc,
    output logic            halted
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, addr_q, addr_d, pc_inc;
    logic [15:0]     instr_q, instr_d;
    logic            rd_q, rd_d;
    logic            idle_go;

    assign pc_inc = pc_q + PC_W'(1);

`ifdef IHS_FETCH_PREFETCH_EN
    logic        pf_pend_q, pf_pend_d;
    logic        buf_load, buf_pop, buf_flush, buf_vld;
    logic [15:0] buf_dat, nxt_word;
    logic        nxt_avail;

    fetch_buffer u_fetch_buffer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (buf_load),
        .load_dat_i (mem_rdata),
        .pop_i      (buf_pop),
        .flush_i    (buf_flush),
        .vld_o      (buf_vld),
        .dat_o      (buf_dat)
    );

    // Word for pc+1 is usable at ack time whether already buffered or arriving this very cycle
    assign nxt_avail = buf_vld | (pf_pend_q & mem_rvalid);
    assign nxt_word  = buf_vld ? buf_dat : mem_rdata;
    // A dropped prefetch still in flight must land before a new read may start
    assign idle_go   = run & ~pf_pend_q;
`else
    assign idle_go   = run;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        rd_d    = 1'b0;
`ifdef IHS_FETCH_PREFETCH_EN
        pf_pend_d = pf_pend_q;
        buf_load  = 1'b0;
        buf_pop   = 1'b0;
        buf_flush = 1'b0;
        if (mem_rvalid && state_q != ST_ISSUE) begin
            pf_pend_d = 1'b0;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (idle_go) begin
                    state_d = ST_FETCH;
                    rd_d    = 1'b1;
                    addr_d  = pc_q;
                end
            end
            ST_FETCH: begin
                // Memory latency is at least one cycle, so rvalid alongside our own strobe is stale
                if (mem_rvalid && !rd_q) begin
                    instr_d = mem_rdata;
                    if (is_hlt(mem_rdata)) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_ISSUE;
`ifdef IHS_FETCH_PREFETCH_EN
                        rd_d      = 1'b1;
                        addr_d    = pc_inc;
                        pf_pend_d = 1'b1;
`endif
                    end
                end
            end
            ST_ISSUE: begin
`ifdef IHS_FETCH_PREFETCH_EN
                if (instr_ack) begin
                    pc_d = pc_inc;
                    if (!run) begin
                        state_d   = ST_IDLE;
                        buf_flush = 1'b1;
                        if (mem_rvalid) begin
                            pf_pend_d = 1'b0;
                        end
                    end else if (nxt_avail) begin
                        instr_d   = nxt_word;
                        buf_pop   = 1'b1;
                        pf_pend_d = 1'b0;
                        if (is_hlt(nxt_word)) begin
                            state_d = ST_HALT;
                        end else begin
                            rd_d      = 1'b1;
                            addr_d    = pc_q + PC_W'(2);
                            pf_pend_d = 1'b1;
                        end
                    end else begin
                        // Prefetch still in flight becomes the read FETCH waits on
                        state_d   = ST_FETCH;
                        pf_pend_d = 1'b0;
                    end
                end else if (pf_pend_q && mem_rvalid) begin
                    buf_load  = 1'b1;
                    pf_pend_d = 1'b0;
                end
`else
                if (instr_ack) begin
                    pc_d = pc_inc;
                    if (run) begin
                        state_d = ST_FETCH;
                        rd_d    = 1'b1;
                        addr_d  = pc_inc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= NOP_WORD;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
        end
    end

`ifdef IHS_FETCH_PREFETCH_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pf_pend_q <= 1'b0;
        end else begin
            pf_pend_q <= pf_pend_d;
        end
    end
`endif

    assign mem_rd_en   = rd_q;
    assign mem_addr    = addr_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALT);
endmodule
